gfx_pixel_coalescer: RTL

Parametrised pixel write-combiner for the gfx memory path. It packs individual coloured pixel writes (8/12/16/24/32 bpp at any bit offset) into a single memory-line buffer of configurable width. It issues one line write with a byte-select mask when any of these occurs: the line changes, the line fills, a flush is requested, or an idle timeout expires. It sits between the rasteriser/blender pixel output and the wide memory write port, cutting write traffic for horizontally adjacent pixels.

---
 rtl/gfx_pixel_coalescer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gfx_pixel_coalescer.sv
// gfx_pixel_coalescer: packs single pixel writes into one memory line and writes
// the line out with a byte-select mask.
// The line is written when the line address changes, the line fills, a flush is
// requested, or the idle timeout expires.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   pix_valid_i / pix_ready_o      pixel handshake
//   pix_adr_i                      line byte address of the pixel
//   pix_mb_i                       bit offset of the pixel in the line
//   pix_color_i                    colour
//   pix_depth_i                    depth code
//   flush_i                        write the buffer out if it holds a line
//   mem_we_o / mem_ack_i           line write request, held until acknowledged
//   mem_adr_o, mem_dat_o,
//   mem_sel_o                      line address, data and byte enables
//   empty_o                        buffer and pending register empty, port idle
module gfx_pixel_coalescer #(
  parameter int MDW = 256,
  parameter int AW = 32,
  parameter bit BPP12 = 1'b0,
  parameter int TIMEOUT = 16,
  localparam int MBW = $clog2(MDW),
  localparam int SELW = MDW / 8,
  localparam int LSB = $clog2(SELW),
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  input  logic [AW-1:0]   pix_adr_i,
  input  logic [MBW-1:0]  pix_mb_i,
  input  logic [31:0]     pix_color_i,
  input  logic [1:0]      pix_depth_i,
  input  logic            flush_i,
  output logic            mem_we_o,
  input  logic            mem_ack_i,
  output logic [AW-1:0]   mem_adr_o,
  output logic [MDW-1:0]  mem_dat_o,
  output logic [SELW-1:0] mem_sel_o,
  output logic            empty_o
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] adr_q, adr_d, padr_q, padr_d, line_i;
  logic [MDW-1:0] dat_q, dat_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pv_q, pv_d;
  logic [MBW-1:0] pmb_q, pmb_d;
  logic [31:0] pcol_q, pcol_d;
  logic [1:0] pdep_q, pdep_d;
  logic acc, same, tmo;
  // Returns {data, sel} with one pixel merged; anything shifted past the line is dropped.
  function automatic logic [MDW+SELW-1:0] merge(input logic [MDW-1:0] d, input logic [SELW-1:0] s,
      input logic [MBW-1:0] mb, input logic [31:0] c, input logic [1:0] dep);
    logic [31:0] m;
    logic [3:0] bm;
    m = dep == 2'd0 ? 32'hFF : dep == 2'd1 ? (BPP12 ? 32'hFFF : 32'hFFFF) :
        dep == 2'd2 ? 32'hFF_FFFF : 32'hFFFF_FFFF;
    bm = dep == 2'd0 ? 4'h1 : dep == 2'd1 ? 4'h3 : dep == 2'd2 ? 4'h7 : 4'hF;
    return {(d & ~(MDW'(m) << mb)) | (MDW'(c & m) << mb),
            (BPP12 && dep == 2'd1) ? {SELW{1'b1}} : s | (SELW'(bm) << mb[MBW-1:3])};
  endfunction
  assign pix_ready_o = state_q != WRITE;
  assign mem_we_o = state_q == WRITE;
  assign empty_o = state_q == IDLE;
  assign mem_adr_o = adr_q;
  assign mem_dat_o = dat_q;
  assign mem_sel_o = sel_q;
  assign acc = pix_valid_i && pix_ready_o;
  assign line_i = (pix_adr_i >> LSB) << LSB;
  assign same = (pix_adr_i >> LSB) == (adr_q >> LSB);
  assign tmo = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    pv_d = pv_q;
    padr_d = padr_q;
    pmb_d = pmb_q;
    pcol_d = pcol_q;
    pdep_d = pdep_q;
    if (state_q == IDLE) begin
      if (acc) begin
        adr_d = line_i;
        {dat_d, sel_d} = merge('0, '0, pix_mb_i, pix_color_i, pix_depth_i);
        cnt_d = '0;
        state_d = &sel_d ? WRITE : FILL;
      end
    end else if (state_q == FILL) begin
      if (acc && same) {dat_d, sel_d} = merge(dat_q, sel_q, pix_mb_i, pix_color_i, pix_depth_i);
      if (acc && !same) begin
        pv_d = 1'b1;
        padr_d = line_i;
        pmb_d = pix_mb_i;
        pcol_d = pix_color_i;
        pdep_d = pix_depth_i;
      end
      cnt_d = acc ? '0 : cnt_q + 1'b1;
      if ((acc && !same) || flush_i || tmo || &sel_d) state_d = WRITE;
    end else if (mem_ack_i) begin
      dat_d = '0;
      sel_d = '0;
      state_d = IDLE;
      // The pending pixel starts the next line; a flush does not apply to it this cycle.
      if (pv_q) begin
        pv_d = 1'b0;
        adr_d = padr_q;
        {dat_d, sel_d} = merge('0, '0, pmb_q, pcol_q, pdep_q);
        cnt_d = '0;
        state_d = &sel_d ? WRITE : FILL;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      pv_q <= 1'b0;
      padr_q <= '0;
      pmb_q <= '0;
      pcol_q <= '0;
      pdep_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      pv_q <= pv_d;
      padr_q <= padr_d;
      pmb_q <= pmb_d;
      pcol_q <= pcol_d;
      pdep_q <= pdep_d;
    end
endmodule
